// File: rtl/kbd_text_pkg.sv
// Shared state encoding, character codes and helpers for the keyboard text buffer.
package kbd_text_pkg;

    typedef enum logic [1:0] {
        CLEAR_ALL = 2'd0,
        IDLE      = 2'd1,
        SCROLL    = 2'd2,
        CLEAR_ROW = 2'd3
    } state_e;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_DEL   = 8'h7F;

    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q];

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_o  <= 1'b0;
            empty_o <= 1'b1;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
            cnt_q   <= cnt_d;
            full_o  <= (cnt_d == CW'(DEPTH));
            empty_o <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/kbd_text_buffer.sv
// COLS x ROWS character-cell screen fed by UART bytes, with cursor and control-code handling.
// Define KBD_TEXT_SCROLL_EN to scroll on a last-row newline; otherwise the cursor wraps to row 0.
module kbd_text_buffer
    import kbd_text_pkg::*;
#(
    parameter int unsigned COLS       = 16,
    parameter int unsigned ROWS       = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    input  logic [$clog2(COLS*ROWS)-1:0]  rd_addr,
    output logic [7:0]                    rd_char,
    output logic [$clog2(ROWS)-1:0]       cursor_row,
    output logic [$clog2(COLS)-1:0]       cursor_col,
    output logic                          busy,
    output logic                          dirty,
    input  logic                          dirty_clr,
    output logic                          overflow
);

    localparam int unsigned CELLS = COLS * ROWS;
    localparam int unsigned AW    = $clog2(CELLS);
    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned CW    = $clog2(COLS);
`ifdef KBD_TEXT_SCROLL_EN
    localparam int unsigned CLR_LAST = CELLS - 1;
`else
    localparam int unsigned CLR_LAST = COLS - 1;
`endif

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [RW-1:0] row_d;
    logic [CW-1:0] col_d;
    logic          prev_cr_q, prev_cr_d;
    logic [7:0]    cells_q [CELLS];

    logic          we_c;
    logic [AW-1:0] waddr_c;
    logic [7:0]    wdata_c;
    logic          pop_c;
    logic          nl_c;
    logic [AW-1:0] cur_addr_c;
    logic [7:0]    fifo_data;
    logic          fifo_full;
    logic          fifo_empty;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rx_valid),
        .data_i  (rx_data),
        .pop_i   (pop_c),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cur_addr_c = AW'(cursor_row) * AW'(COLS) + AW'(cursor_col);

    // Next-state: byte interpretation in IDLE, cell sweeps in the busy states.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        row_d     = cursor_row;
        col_d     = cursor_col;
        prev_cr_d = prev_cr_q;
        we_c      = 1'b0;
        waddr_c   = ptr_q;
        wdata_c   = CH_SPACE;
        pop_c     = 1'b0;
        nl_c      = 1'b0;
        case (state_q)
            CLEAR_ALL: begin
                we_c = 1'b1;
                if (ptr_q == AW'(CELLS - 1)) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            IDLE: begin
                if (!fifo_empty) begin
                    pop_c     = 1'b1;
                    prev_cr_d = (fifo_data == CH_CR);
                    if (is_printable(fifo_data)) begin
                        we_c    = 1'b1;
                        waddr_c = cur_addr_c;
                        wdata_c = fifo_data;
                        if (cursor_col == CW'(COLS - 1)) nl_c = 1'b1;
                        else                             col_d = cursor_col + CW'(1);
                    end else if (fifo_data == CH_BS || fifo_data == CH_DEL) begin
                        // Previous cell is always cur_addr-1, including the wrap to the row above.
                        if (cursor_col != '0) begin
                            col_d   = cursor_col - CW'(1);
                            we_c    = 1'b1;
                            waddr_c = cur_addr_c - AW'(1);
                        end else if (cursor_row != '0) begin
                            row_d   = cursor_row - RW'(1);
                            col_d   = CW'(COLS - 1);
                            we_c    = 1'b1;
                            waddr_c = cur_addr_c - AW'(1);
                        end
                    end else if (fifo_data == CH_CR) begin
                        nl_c = 1'b1;
                    end else if (fifo_data == CH_LF) begin
                        nl_c = !prev_cr_q;
                    end else if (fifo_data == CH_FF) begin
                        row_d   = '0;
                        col_d   = '0;
                        ptr_d   = '0;
                        state_d = CLEAR_ALL;
                    end
                    if (nl_c) begin
                        col_d = '0;
                        ptr_d = '0;
                        if (cursor_row != RW'(ROWS - 1)) begin
                            row_d = cursor_row + RW'(1);
                        end else begin
`ifdef KBD_TEXT_SCROLL_EN
                            state_d = SCROLL;
`else
                            row_d   = '0;
                            state_d = CLEAR_ROW;
`endif
                        end
                    end
                end
            end
`ifdef KBD_TEXT_SCROLL_EN
            SCROLL: begin
                we_c    = 1'b1;
                wdata_c = cells_q[ptr_q + AW'(COLS)];
                ptr_d   = ptr_q + AW'(1);
                if (ptr_q == AW'(CELLS - COLS - 1)) state_d = CLEAR_ROW;
            end
`endif
            CLEAR_ROW: begin
                we_c = 1'b1;
                if (ptr_q == AW'(CLR_LAST)) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= CLEAR_ALL;
            ptr_q      <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            prev_cr_q  <= 1'b0;
            busy       <= 1'b1;
            dirty      <= 1'b1;
            overflow   <= 1'b0;
            rd_char    <= CH_SPACE;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cursor_row <= row_d;
            cursor_col <= col_d;
            prev_cr_q  <= prev_cr_d;
            busy       <= (state_d != IDLE);
            if (we_c || row_d != cursor_row || col_d != cursor_col) dirty <= 1'b1;
            else if (dirty_clr)                                     dirty <= 1'b0;
            if (rx_valid && fifo_full && !pop_c) overflow <= 1'b1;
            rd_char    <= cells_q[rd_addr];
        end
    end

    // Single cell write port; held off while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && we_c) cells_q[waddr_c] <= wdata_c;
    end

endmodule

// File: tb/tb_kbd_text_buffer.sv
// Randomized bench for kbd_text_buffer against a screen-level reference model.
module tb_kbd_text_buffer;

    localparam int COLS  = 16;
    localparam int ROWS  = 4;
    localparam int DEPTH = 4;
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          dirty_clr = 1'b0;
    logic [7:0]    rd_char;
    logic [1:0]    cursor_row;
    logic [3:0]    cursor_col;
    logic          busy, dirty, overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_scr [CELLS];
    int         m_row, m_col;
    bit         m_prev_cr, m_dirty, m_ovf;

    kbd_text_buffer #(.COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rd_addr    (rd_addr),
        .rd_char    (rd_char),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy),
        .dirty      (dirty),
        .dirty_clr  (dirty_clr),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void m_clear_row(input int r);
        for (int c = 0; c < COLS; c++) m_scr[r*COLS + c] = 8'h20;
    endfunction

    function automatic void m_clear_all();
        for (int r = 0; r < ROWS; r++) m_clear_row(r);
    endfunction

    function automatic void m_newline();
        m_col   = 0;
        m_dirty = 1;
        if (m_row < ROWS - 1) begin
            m_row++;
        end else begin
`ifdef KBD_TEXT_SCROLL_EN
            for (int a = 0; a < CELLS - COLS; a++) m_scr[a] = m_scr[a + COLS];
            m_clear_row(ROWS - 1);
`else
            m_row = 0;
            m_clear_row(0);
`endif
        end
    endfunction

    function automatic void m_exec(input logic [7:0] b);
        bit was_cr;
        was_cr    = m_prev_cr;
        m_prev_cr = (b == 8'h0D);
        if (b >= 8'h20 && b <= 8'h7E) begin
            m_scr[m_row*COLS + m_col] = b;
            m_dirty = 1;
            if (m_col == COLS - 1) m_newline();
            else                   m_col++;
        end else if (b == 8'h08 || b == 8'h7F) begin
            if (m_col > 0) begin
                m_col--;
            end else if (m_row > 0) begin
                m_row--;
                m_col = COLS - 1;
            end else begin
                return;
            end
            m_scr[m_row*COLS + m_col] = 8'h20;
            m_dirty = 1;
        end else if (b == 8'h0D) begin
            m_newline();
        end else if (b == 8'h0A) begin
            if (!was_cr) m_newline();
        end else if (b == 8'h0C) begin
            m_clear_all();
            m_row   = 0;
            m_col   = 0;
            m_dirty = 1;
        end
    endfunction

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(99);
        if (r < 62)      return 8'($urandom_range(8'h7E, 8'h20));
        else if (r < 70) return 8'h08;
        else if (r < 74) return 8'h7F;
        else if (r < 86) return 8'h0D;
        else if (r < 97) return 8'h0A;
        else             return 8'h0C;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit model = 1'b1);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        if (model) m_exec(b);
    endtask

    task automatic settle(input string tag);
        int quiet  = 0;
        int cycles = 0;
        while (quiet < 8 && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            if (busy) quiet = 0;
            else      quiet++;
        end
        chk({tag, " settle"}, 32'(quiet), 32'd8);
        tick();
    endtask

    task automatic read_cell(input int a, output logic [7:0] v);
        rd_addr = AW'(a);
        @(posedge clk);
        @(negedge clk);
        v = rd_char;
        tick();
    endtask

    task automatic check_all(input string tag);
        logic [7:0] v;
        @(negedge clk);
        chk({tag, " row"},      32'(cursor_row), 32'(m_row));
        chk({tag, " col"},      32'(cursor_col), 32'(m_col));
        chk({tag, " busy"},     32'(busy),       32'd0);
        chk({tag, " dirty"},    32'(dirty),      32'(m_dirty));
        chk({tag, " overflow"}, 32'(overflow),   32'(m_ovf));
        for (int a = 0; a < CELLS; a++) begin
            read_cell(a, v);
            chk($sformatf("%s cell%0d", tag, a), 32'(v), 32'(m_scr[a]));
        end
    endtask

    task automatic clear_dirty();
        dirty_clr = 1'b1;
        tick();
        dirty_clr = 1'b0;
        m_dirty   = 0;
    endtask

    task automatic reset_and_check(input string tag);
        int cnt = 0;
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk({tag, " rst busy"},     32'(busy),       32'd1);
        chk({tag, " rst dirty"},    32'(dirty),      32'd1);
        chk({tag, " rst overflow"}, 32'(overflow),   32'd0);
        chk({tag, " rst row"},      32'(cursor_row), 32'd0);
        chk({tag, " rst col"},      32'(cursor_col), 32'd0);
        chk({tag, " rst rd_char"},  32'(rd_char),    32'h20);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (busy) cnt++;
            else      break;
        end
        chk({tag, " busy_len"}, 32'(cnt), 32'(CELLS));
        m_clear_all();
        m_row = 0; m_col = 0; m_prev_cr = 0; m_dirty = 1; m_ovf = 0;
        tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] v;
        int nb;

        reset_and_check("init");
        check_all("init");

        clear_dirty();
        send("H"); send("i");
        settle("hi");
        read_cell(0, v); chk("hi cell0", 32'(v), 32'h48);
        read_cell(1, v); chk("hi cell1", 32'(v), 32'h69);
        check_all("hi");

        send(8'h08);
        settle("bs");
        chk("bs col", 32'(cursor_col), 32'd1);
        check_all("bs");

        send(8'h0D); send(8'h0A);
        settle("crlf");
        chk("crlf row", 32'(cursor_row), 32'd1);
        check_all("crlf");
        send(8'h0A);
        settle("lf");
        check_all("lf");

        clear_dirty();
        send(8'h01);
        settle("ignored");
        check_all("ignored");

        send(8'h0C);
        settle("ff");
        clear_dirty();
        send(8'h7F);
        settle("del_origin");
        check_all("del_origin");

        send(8'h0A); send(8'h0A); send(8'h0A);
        settle("to_last");
        for (int i = 0; i < COLS; i++) send("A");
        send("B");
        settle("lastrow");
        check_all("lastrow");

        // Write executing in the same cycle as dirty_clr must leave dirty set.
        clear_dirty();
        @(negedge clk);
        chk("pre_coinc dirty", 32'(dirty), 32'd0);
        tick();
        rx_data = "x"; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0; dirty_clr = 1'b1;
        tick();
        dirty_clr = 1'b0;
        m_exec("x");
        @(negedge clk);
        chk("coinc dirty", 32'(dirty), 32'd1);
        tick();
        settle("coinc");
        check_all("coinc");

        // Six back-to-back bytes while clearing: four fit, two are dropped.
        send(8'h0C);
        for (int i = 0; i < 6; i++) send(8'("a" + i), i < 4);
        m_ovf = 1;
        settle("ovf");
        chk("ovf flag", 32'(overflow), 32'd1);
        check_all("ovf");

        for (int burst = 0; burst < 50; burst++) begin
            clear_dirty();
            nb = $urandom_range(4, 1);
            for (int i = 0; i < nb; i++) begin
                send(rand_byte());
                repeat ($urandom_range(2)) tick();
            end
            settle($sformatf("rnd%0d", burst));
            check_all($sformatf("rnd%0d", burst));
        end

        send(8'h0C);
        repeat (10) tick();
        reset_and_check("midclear");
        check_all("midclear");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
